// File: rtl/mem_stage_unit.sv
// Memory stage: turns buffered loads/stores into a req/ack data-memory transaction,
// stalls the front of the pipeline while it is outstanding, and builds the M/W register.
module mem_stage_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_result,
    input  logic [31:0] jump_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  write_reg_addr,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_reg,
    input  logic        branch,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pc_select,
    output logic [31:0] pc_target,
    output logic [31:0] alu_result_buffered,
    output logic [31:0] read_data_buffered,
    output logic [4:0]  write_reg_addr_buffered,
    output logic        mem_reg_buffered,
    output logic        reg_write_buffered,
    output logic        bus_error
);

    localparam logic [0:0]    IDLE   = 1'b0;
    localparam logic [0:0]    ACCESS = 1'b1;
    localparam logic [CW-1:0] LAST   = CW'(TIMEOUT - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [31:0]   alu_buf_q, alu_buf_d;
    logic [31:0]   rdata_buf_q, rdata_buf_d;
    logic [4:0]    wra_buf_q, wra_buf_d;
    logic          mreg_buf_q, mreg_buf_d;
    logic          rw_buf_q, rw_buf_d;
    logic          mem_op;
    logic          timeout_hit;
    logic          stall_raw;

    assign mem_op      = mem_read | mem_write;
    assign timeout_hit = (count_q == LAST);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        alu_buf_d   = alu_buf_q;
        rdata_buf_d = rdata_buf_q;
        wra_buf_d   = wra_buf_q;
        mreg_buf_d  = mreg_buf_q;
        rw_buf_d    = rw_buf_q;
        stall_raw   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall_raw = 1'b1;
                    state_d   = ACCESS;
                    req_d     = 1'b1;
                    we_d      = mem_write;
                    addr_d    = alu_result;
                    wdata_d   = store_data;
                    count_d   = '0;
                    rw_buf_d  = 1'b0;
                end else begin
                    alu_buf_d   = alu_result;
                    rdata_buf_d = '0;
                    wra_buf_d   = write_reg_addr;
                    mreg_buf_d  = mem_reg;
                    rw_buf_d    = reg_write;
                end
            end
            ACCESS: begin
                // Ack wins over a coincident timeout; a timeout releases the stall so the
                // aborted instruction leaves X/M instead of being reissued.
                stall_raw = ~dmem_ack & ~timeout_hit;
                if (dmem_ack) begin
                    rdata_buf_d = we_q ? 32'h0 : dmem_rdata;
                    alu_buf_d   = alu_result;
                    wra_buf_d   = write_reg_addr;
                    mreg_buf_d  = mem_reg;
                    rw_buf_d    = reg_write;
                    req_d       = 1'b0;
                    state_d     = IDLE;
                end else if (timeout_hit) begin
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    rw_buf_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    count_d  = count_q + CW'(1);
                    rw_buf_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            alu_buf_q   <= '0;
            rdata_buf_q <= '0;
            wra_buf_q   <= '0;
            mreg_buf_q  <= 1'b0;
            rw_buf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            alu_buf_q   <= alu_buf_d;
            rdata_buf_q <= rdata_buf_d;
            wra_buf_q   <= wra_buf_d;
            mreg_buf_q  <= mreg_buf_d;
            rw_buf_q    <= rw_buf_d;
        end
    end

    // Stall is forced low while reset is asserted, even if a mem op is presented.
    assign stall                   = rst_n & stall_raw;
    assign pc_select               = branch & ~stall;
    assign pc_target               = jump_result;
    assign dmem_req                = req_q;
    assign dmem_we                 = we_q;
    assign dmem_addr               = addr_q;
    assign dmem_wdata              = wdata_q;
    assign bus_error               = err_q;
    assign alu_result_buffered     = alu_buf_q;
    assign read_data_buffered      = rdata_buf_q;
    assign write_reg_addr_buffered = wra_buf_q;
    assign mem_reg_buffered        = mreg_buf_q;
    assign reg_write_buffered      = rw_buf_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Randomised bench for mem_stage_unit: each instruction is expanded by a
// transaction-level model into its expected per-cycle stall/request and M/W results.
module tb_mem_stage_unit;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_result, jump_result, store_data;
    logic [4:0]  write_reg_addr;
    logic        reg_write, mem_read, mem_write, mem_reg, branch;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, pc_select;
    logic [31:0] pc_target, alu_result_buffered, read_data_buffered;
    logic [4:0]  write_reg_addr_buffered;
    logic        mem_reg_buffered, reg_write_buffered, bus_error;

    int checks = 0;
    int errors = 0;
    logic err_exp = 1'b0;

    mem_stage_unit #(.TIMEOUT(T), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result(alu_result), .jump_result(jump_result), .store_data(store_data),
        .write_reg_addr(write_reg_addr), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_reg(mem_reg), .branch(branch),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .pc_select(pc_select), .pc_target(pc_target),
        .alu_result_buffered(alu_result_buffered), .read_data_buffered(read_data_buffered),
        .write_reg_addr_buffered(write_reg_addr_buffered),
        .mem_reg_buffered(mem_reg_buffered), .reg_write_buffered(reg_write_buffered),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One instruction held in X/M. lat = number of no-ack ACCESS cycles before the ack;
    // lat >= T means the memory never answers and the access times out.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] alu,
                          input logic [31:0] sdata, input logic [4:0] wra, input logic rw,
                          input logic mreg, input logic br, input logic [31:0] jmp,
                          input int lat, input logic [31:0] rdata);
        int  n;
        bit  acked;
        alu_result = alu; store_data = sdata; write_reg_addr = wra; reg_write = rw;
        mem_read = rd; mem_write = wr; mem_reg = mreg; branch = br; jump_result = jmp;
        dmem_rdata = $urandom;
        if (!rd && !wr) begin
            dmem_ack = 1'($urandom);  // ack in IDLE must be ignored
            #1;
            check_eq("nm_stall", 32'(stall), 32'd0);
            check_eq("nm_req", 32'(dmem_req), 32'd0);
            check_eq("nm_pcsel", 32'(pc_select), 32'(br));
            check_eq("nm_pctgt", pc_target, jmp);
            next_cycle();
            dmem_ack = 1'b0;
            check_eq("nm_alu_buf", alu_result_buffered, alu);
            check_eq("nm_rdata_buf", read_data_buffered, 32'd0);
            check_eq("nm_wra_buf", 32'(write_reg_addr_buffered), 32'(wra));
            check_eq("nm_mreg_buf", 32'(mem_reg_buffered), 32'(mreg));
            check_eq("nm_rw_buf", 32'(reg_write_buffered), 32'(rw));
            check_eq("nm_err", 32'(bus_error), 32'(err_exp));
            return;
        end
        dmem_ack = 1'b0;
        acked = (lat < int'(T));
        n = acked ? lat + 1 : int'(T);
        #1;
        check_eq("op_idle_stall", 32'(stall), 32'd1);
        check_eq("op_idle_req", 32'(dmem_req), 32'd0);
        check_eq("op_idle_pcsel", 32'(pc_select), 32'd0);
        next_cycle();
        check_eq("op_bubble", 32'(reg_write_buffered), 32'd0);
        for (int k = 1; k <= n; k++) begin
            dmem_ack = acked && (k == n);
            dmem_rdata = dmem_ack ? rdata : $urandom;
            #1;
            check_eq("acc_req", 32'(dmem_req), 32'd1);
            check_eq("acc_we", 32'(dmem_we), 32'(wr));
            check_eq("acc_addr", dmem_addr, alu);
            check_eq("acc_wdata", dmem_wdata, sdata);
            check_eq("acc_stall", 32'(stall), 32'(k != n));
            check_eq("acc_pcsel", 32'(pc_select), 32'(br && (k == n)));
            check_eq("acc_pctgt", pc_target, jmp);
            next_cycle();
            dmem_ack = 1'b0;
            if (k < n) check_eq("acc_bubble", 32'(reg_write_buffered), 32'd0);
        end
        if (acked) begin
            check_eq("ret_alu_buf", alu_result_buffered, alu);
            check_eq("ret_rdata_buf", read_data_buffered, wr ? 32'd0 : rdata);
            check_eq("ret_wra_buf", 32'(write_reg_addr_buffered), 32'(wra));
            check_eq("ret_mreg_buf", 32'(mem_reg_buffered), 32'(mreg));
            check_eq("ret_rw_buf", 32'(reg_write_buffered), 32'(rw));
        end else begin
            err_exp = 1'b1;
            check_eq("to_bubble", 32'(reg_write_buffered), 32'd0);
        end
        check_eq("post_req", 32'(dmem_req), 32'd0);
        check_eq("post_err", 32'(bus_error), 32'(err_exp));
    endtask

    initial begin
        rst_n = 1'b0;
        alu_result = '0; jump_result = '0; store_data = '0; write_reg_addr = '0;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_reg = 1'b0;
        branch = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) next_cycle();
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_rw_buf", 32'(reg_write_buffered), 32'd0);
        check_eq("rst_alu_buf", alu_result_buffered, 32'd0);
        check_eq("rst_err", 32'(bus_error), 32'd0);
        rst_n = 1'b1;

        run_op(0, 0, 32'h10, 32'h0, 5'd3, 1, 0, 0, 32'h0, 0, 32'h0);
        run_op(1, 0, 32'h100, 32'h0, 5'd7, 1, 1, 1, 32'h40, 3, 32'hDEADBEEF);
        run_op(1, 0, 32'h104, 32'h0, 5'd8, 1, 1, 0, 32'h0, 2, 32'hCAFEF00D);
        run_op(0, 1, 32'h200, 32'h55, 5'd0, 0, 0, 0, 32'h0, 0, 32'h0);
        run_op(1, 1, 32'h204, 32'h66, 5'd1, 0, 0, 0, 32'h0, 1, 32'h12345678);
        run_op(1, 0, 32'h300, 32'h0, 5'd9, 1, 1, 1, 32'h40, 99, 32'h0);
        run_op(0, 0, 32'h20, 32'h0, 5'd4, 1, 0, 1, 32'h44, 0, 32'h0);

        // Reset in the middle of an access: everything drops at once, stale ack ignored.
        alu_result = 32'h400; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
        branch = 1'b0; dmem_ack = 1'b0;
        repeat (3) next_cycle();
        check_eq("mid_req_before", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(dmem_req), 32'd0);
        check_eq("mid_rst_stall", 32'(stall), 32'd0);
        check_eq("mid_rst_err", 32'(bus_error), 32'd0);
        check_eq("mid_rst_rw", 32'(reg_write_buffered), 32'd0);
        check_eq("mid_rst_alu", alu_result_buffered, 32'd0);
        err_exp = 1'b0;
        mem_read = 1'b0; reg_write = 1'b0; alu_result = '0;
        next_cycle();
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        next_cycle();
        dmem_ack = 1'b0;
        check_eq("late_ack_req", 32'(dmem_req), 32'd0);
        check_eq("late_ack_err", 32'(bus_error), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic rd, wr;
            int   lat;
            int   kind;
            kind = $urandom_range(0, 3);
            rd = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
            wr = (kind == 2) || (kind == 3);
            lat = ($urandom_range(0, 5) == 0) ? int'(T) + 2 : $urandom_range(0, T - 1);
            run_op(rd, wr, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom, lat, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
